// File: rtl/store_buffer_if.sv
// M-stage / data-memory bundle seen by the store buffer.
// The slave modport is the buffer; the master modport is the pipeline plus data memory.
interface store_buffer_if;
  logic        Mem_Read_M;
  logic        Mem_Write_M;
  logic [31:0] ALU_Result_M;
  logic [31:0] Write_Data_M;
  logic [31:0] Read_Data_Mem;
  logic        Mem_Read_D;
  logic        Mem_Write_D;
  logic [31:0] Addr_D;
  logic [31:0] Wdata_D;
  logic [31:0] Read_Data_M;
  logic        Stall_M;
  logic        Empty;

  modport master (
    output Mem_Read_M, Mem_Write_M, ALU_Result_M, Write_Data_M, Read_Data_Mem,
    input  Mem_Read_D, Mem_Write_D, Addr_D, Wdata_D, Read_Data_M, Stall_M, Empty
  );

  modport slave (
    input  Mem_Read_M, Mem_Write_M, ALU_Result_M, Write_Data_M, Read_Data_Mem,
    output Mem_Read_D, Mem_Write_D, Addr_D, Wdata_D, Read_Data_M, Stall_M, Empty
  );
endinterface

// File: rtl/store_buffer.sv
// FIFO store buffer between the M stage and data memory; loads stall while any pending store overlaps them.
// Define STORE_FWD_EN to forward the youngest exact-address store to a load instead of stalling.
module store_buffer #(
  parameter int DEPTH = 4
) (
  input logic          clk,
  input logic          rst,
  store_buffer_if.slave sb
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [31:0]      addr_mem [DEPTH];
  logic [31:0]      data_mem [DEPTH];
  logic [PTR_W-1:0] head_reg;
  logic [PTR_W-1:0] tail_reg;
  logic [CNT_W-1:0] count_reg;

  logic [DEPTH-1:0] overlap_vec;
  logic             is_empty;
  logic             is_full;
  logic             store_only;
  logic             bus_idle;
  logic             hazard;
  logic             push;
  logic             pop;
  logic             fwd_hit;
  logic [31:0]      fwd_data;

  // An entry is live when its distance from head is below count; overlap is |A-B| < 4.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [PTR_W-1:0] age;
      logic             live;
      logic [31:0]      diff_fwd;
      logic [31:0]      diff_bwd;
      assign age      = PTR_W'(gi) - head_reg;
      assign live     = {1'b0, age} < count_reg;
      assign diff_fwd = sb.ALU_Result_M - addr_mem[gi];
      assign diff_bwd = addr_mem[gi] - sb.ALU_Result_M;
      assign overlap_vec[gi] = live && ((diff_fwd < 32'd4) || (diff_bwd < 32'd4));
    end
  endgenerate

`ifdef STORE_FWD_EN
  logic [DEPTH-1:0] exact_vec;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_exact
      assign exact_vec[gi] = g_entry[gi].live && (addr_mem[gi] == sb.ALU_Result_M);
    end
  endgenerate

  // Walk from oldest to youngest so the last hit (youngest store) wins.
  always_comb begin
    logic [PTR_W-1:0] idx;
    fwd_data = '0;
    idx      = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_reg + PTR_W'(k);
      if (exact_vec[idx]) begin
        fwd_data = data_mem[idx];
      end
    end
  end

  assign fwd_hit = sb.Mem_Read_M && (|exact_vec);
`else
  assign fwd_hit  = 1'b0;
  assign fwd_data = '0;
`endif

  assign is_empty   = (count_reg == '0);
  assign is_full    = (count_reg == CNT_W'(DEPTH));
  assign store_only = sb.Mem_Write_M && !sb.Mem_Read_M;
  assign bus_idle   = !sb.Mem_Read_M && !sb.Mem_Write_M;
  assign hazard     = sb.Mem_Read_M && (|overlap_vec) && !fwd_hit;
  assign push       = store_only;
  // A store into a full buffer retires the head in the same cycle, so stores never stall.
  assign pop        = !is_empty && (bus_idle || (store_only && is_full) || hazard);

  always_comb begin
    sb.Mem_Write_D = pop;
    sb.Mem_Read_D  = 1'b0;
    sb.Addr_D      = '0;
    sb.Wdata_D     = '0;
    sb.Read_Data_M = '0;
    sb.Stall_M     = hazard;
    sb.Empty       = is_empty;
    if (pop) begin
      sb.Addr_D  = addr_mem[head_reg];
      sb.Wdata_D = data_mem[head_reg];
    end else if (sb.Mem_Read_M && !fwd_hit) begin
      sb.Mem_Read_D = 1'b1;
      sb.Addr_D     = sb.ALU_Result_M;
    end
    if (sb.Mem_Read_M && !hazard) begin
      sb.Read_Data_M = fwd_hit ? fwd_data : sb.Read_Data_Mem;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (push) begin
        tail_reg <= tail_reg + PTR_W'(1);
      end
      if (pop) begin
        head_reg <= head_reg + PTR_W'(1);
      end
      if (push && !pop) begin
        count_reg <= count_reg + CNT_W'(1);
      end else if (pop && !push) begin
        count_reg <= count_reg - CNT_W'(1);
      end
    end
  end

  // Entry storage carries no reset; liveness comes from head/count alone.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[tail_reg] <= sb.ALU_Result_M;
      data_mem[tail_reg] <= sb.Write_Data_M;
    end
  end
endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: memory writes are checked against a queue of accepted stores.
// Data memory is modelled as Read_Data_Mem = Addr_D ^ KEY.
module tb_store_buffer;
  localparam int          DEPTH = 4;
  localparam logic [31:0] KEY   = 32'hC0DE_0000;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  wr_t  exp_wr[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   n_writes = 0;
  int   w0;

  always #5 clk = ~clk;

  store_buffer_if sb();
  store_buffer #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .sb(sb));

  assign sb.Read_Data_Mem = sb.Addr_D ^ KEY;

  task automatic check32(string tag, logic [31:0] obs, logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check1(string tag, logic obs, logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic drive(logic rd, logic wr, logic [31:0] a, logic [31:0] d);
    sb.Mem_Read_M   = rd;
    sb.Mem_Write_M  = wr;
    sb.ALU_Result_M = a;
    sb.Write_Data_M = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Move to the falling edge and score any memory write against the oldest accepted store.
  task automatic settle();
    wr_t w;
    @(negedge clk);
    if (sb.Mem_Write_D && !rst) begin
      n_writes++;
      n_assert++;
      assert (exp_wr.size() != 0) else begin
        n_fail++;
        $error("FAIL spurious_write: observed write addr %h, expected no write", sb.Addr_D);
      end
      if (exp_wr.size() != 0) begin
        w = exp_wr.pop_front();
        $display("mem write  addr=%h data=%h", sb.Addr_D, sb.Wdata_D);
        check32("wr_addr", sb.Addr_D, w.addr);
        check32("wr_data", sb.Wdata_D, w.data);
      end
    end
  endtask

  task automatic do_store(logic [31:0] a, logic [31:0] d);
    drive(1'b0, 1'b1, a, d);
    exp_wr.push_back({a, d});
    settle();
    $display("store      addr=%h data=%h", a, d);
    check1("store_no_stall", sb.Stall_M, 1'b0);
    tick();
  endtask

  task automatic do_load(logic [31:0] a, logic [31:0] exp_data, int exp_stalls, logic exp_rd);
    int stalls = 0;
    bit done   = 1'b0;
    drive(1'b1, 1'b0, a, 32'h0);
    for (int c = 0; c < 16 && !done; c++) begin
      settle();
      if (sb.Stall_M) begin
        check1("stall_rd_off", sb.Mem_Read_D, 1'b0);
        check32("stall_rdata", sb.Read_Data_M, 32'h0);
        stalls++;
        tick();
      end else begin
        done = 1'b1;
      end
    end
    $display("load       addr=%h data=%h stalls=%0d", a, sb.Read_Data_M, stalls);
    check1("load_done", done, 1'b1);
    check32("load_stalls", 32'(stalls), 32'(exp_stalls));
    check1("load_mem_rd", sb.Mem_Read_D, exp_rd);
    if (exp_rd) check32("load_addr", sb.Addr_D, a);
    check32("load_data", sb.Read_Data_M, exp_data);
    tick();
  endtask

  task automatic do_idle();
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    settle();
    check32("idle_rdata", sb.Read_Data_M, 32'h0);
    tick();
  endtask

  initial begin
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    settle();
    check1("rst_empty", sb.Empty, 1'b1);
    check1("rst_wr", sb.Mem_Write_D, 1'b0);
    check1("rst_stall", sb.Stall_M, 1'b0);
    check1("rst_rd", sb.Mem_Read_D, 1'b0);
    check32("rst_rdata", sb.Read_Data_M, 32'h0);
    tick();

    // Single store drains on the following idle cycle
    do_store(32'h10, 32'h1122_3344);
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    settle();
    check1("idle_wr", sb.Mem_Write_D, 1'b1);
    check32("idle_addr", sb.Addr_D, 32'h10);
    check32("idle_wdata", sb.Wdata_D, 32'h1122_3344);
    check1("idle_not_empty", sb.Empty, 1'b0);
    check32("idle_rdata0", sb.Read_Data_M, 32'h0);
    tick();
    settle();
    check1("drained_empty", sb.Empty, 1'b1);
    tick();

    // Fill to DEPTH with interleaved non-overlapping loads, then store into the full buffer
    for (int i = 0; i < DEPTH; i++) begin
      do_store(32'(i * 4), 32'hA000_0000 + 32'(i));
      if (i < 2) do_load(32'h40 << i, (32'h40 << i) ^ KEY, 0, 1'b1);
    end
    drive(1'b0, 1'b1, 32'h50, 32'h5050_5050);
    exp_wr.push_back({32'h50, 32'h5050_5050});
    settle();
    $display("store      addr=%h data=%h (full)", 32'h50, 32'h5050_5050);
    check1("full_no_stall", sb.Stall_M, 1'b0);
    check1("full_head_wr", sb.Mem_Write_D, 1'b1);
    check32("full_head_addr", sb.Addr_D, 32'h0);
    tick();
    do_load(32'h100, 32'h100 ^ KEY, 0, 1'b1);
    w0 = n_writes;
    repeat (DEPTH + 2) do_idle();
    check32("full_count_kept", 32'(n_writes - w0), 32'(DEPTH));
    settle();
    check1("full_drained_empty", sb.Empty, 1'b1);
    tick();

    // Partial overlap stalls until the entry drains
    do_store(32'h20, 32'h2020_2020);
    do_load(32'h22, 32'h22 ^ KEY, 1, 1'b1);
    check32("overlap_drained", 32'(exp_wr.size()), 32'd0);

    // Exact match with a younger non-overlapping store behind it
    do_store(32'h24, 32'h2424_2424);
    do_store(32'h30, 32'h3030_3030);
`ifdef STORE_FWD_EN
    do_load(32'h24, 32'h2424_2424, 0, 1'b0);
`else
    do_load(32'h24, 32'h24 ^ KEY, 1, 1'b1);
`endif
    repeat (3) do_idle();

    // Two stores to the same address, then an immediate load of it
    do_store(32'h20, 32'hAAAA_5555);
    do_store(32'h20, 32'h1234_5678);
`ifdef STORE_FWD_EN
    do_load(32'h20, 32'h1234_5678, 0, 1'b0);
`else
    do_load(32'h20, 32'h20 ^ KEY, 2, 1'b1);
`endif
    repeat (3) do_idle();
    check32("same_addr_drained", 32'(exp_wr.size()), 32'd0);

    // Read+write together is a load only; the store is dropped
    do_store(32'h80, 32'h8080_8080);
    drive(1'b1, 1'b1, 32'h30, 32'hDEAD_BEEF);
    settle();
    $display("load+store addr=%h data=%h", 32'h30, sb.Read_Data_M);
    check1("rw_no_stall", sb.Stall_M, 1'b0);
    check1("rw_mem_rd", sb.Mem_Read_D, 1'b1);
    check1("rw_no_wr", sb.Mem_Write_D, 1'b0);
    check32("rw_addr", sb.Addr_D, 32'h30);
    check32("rw_rdata", sb.Read_Data_M, 32'h30 ^ KEY);
    tick();
    w0 = n_writes;
    repeat (3) do_idle();
    check32("rw_count_kept", 32'(n_writes - w0), 32'd1);
    settle();
    check1("rw_empty", sb.Empty, 1'b1);
    tick();

    // Reset discards pending stores
    do_store(32'h100, 32'h0000_0100);
    do_store(32'h104, 32'h0000_0104);
    do_store(32'h108, 32'h0000_0108);
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    rst = 1'b1;
    exp_wr.delete();
    tick();
    rst = 1'b0;
    $display("reset with three pending stores");
    settle();
    check1("rst2_empty", sb.Empty, 1'b1);
    check1("rst2_wr", sb.Mem_Write_D, 1'b0);
    tick();
    w0 = n_writes;
    repeat (4) do_idle();
    check32("rst2_no_writes", 32'(n_writes - w0), 32'd0);

    check32("scoreboard_empty", 32'(exp_wr.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
